// File: rtl/mem_access_unit.sv
// Load/store front end: turns one byte-addressed request into 8-byte-aligned
// memory beats with lane masks, and merges/extends load data from those beats.
module mem_access_unit #(
  parameter bit PROBE_SPLIT_STORES = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_addr,
  input  logic        req_store,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_data,
  output logic        rsp_fault,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_data,
  output logic        mem_wren,
  output logic [7:0]  mem_mask,
  input  logic [63:0] mem_resp,
  input  logic        mem_exc
);

  typedef enum logic [2:0] {IDLE, PROBE, LO, HI, RESP} state_t;

  state_t      state_reg, state_next;
  logic [63:0] addr_reg, addr_next;
  logic [63:0] wdata_reg, wdata_next;
  logic        store_reg, store_next;
  logic [1:0]  size_reg, size_next;
  logic        uns_reg, uns_next;
  logic [63:0] acc_reg, acc_next;
  logic        fault_reg, fault_next;
  logic [63:0] rdata_reg, rdata_next;

  logic [2:0]  off;
  logic [63:0] base_addr, hi_addr;
  logic [4:0]  lane_end;
  logic [15:0] m16;
  logic        split, req_split, beat_write;
  logic [6:0]  lo_shift, hi_shift;
  logic [63:0] lo_wdata, hi_wdata, lo_lane, hi_lane;

  assign off       = addr_reg[2:0];
  assign base_addr = {addr_reg[63:3], 3'b000};
  assign hi_addr   = base_addr + 64'd8;
  assign lane_end  = {2'b00, off} + (5'd1 << size_reg);

  // Byte lane i of the 16-byte window [base, base+16) is touched when off <= i < off+size.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_lane
      assign m16[gi] = (5'(gi) >= {2'b00, off}) && (5'(gi) < lane_end);
    end
  endgenerate

  assign split      = |m16[15:8];
  assign req_split  = ({2'b00, req_addr[2:0]} + (5'd1 << req_size)) > 5'd8;
  assign lo_shift   = {1'b0, off, 3'b000};
  // Only meaningful when split, which implies off >= 1, so the shift stays below 64.
  assign hi_shift   = 7'd64 - lo_shift;
  assign lo_wdata   = wdata_reg << lo_shift;
  assign hi_wdata   = wdata_reg >> hi_shift;
  assign lo_lane    = mem_resp >> lo_shift;
  assign hi_lane    = mem_resp << hi_shift;
  assign beat_write = store_reg && !mem_exc;

  assign rsp_data  = rdata_reg;
  assign rsp_fault = fault_reg;

  function automatic logic [63:0] extend(input logic [63:0] v, input logic [1:0] sz,
                                         input logic uns);
    logic [63:0] r;
    case (sz)
      2'd0:    r = {{56{~uns & v[7]}},  v[7:0]};
      2'd1:    r = {{48{~uns & v[15]}}, v[15:0]};
      2'd2:    r = {{32{~uns & v[31]}}, v[31:0]};
      default: r = v;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      wdata_reg <= '0;
      store_reg <= 1'b0;
      size_reg  <= '0;
      uns_reg   <= 1'b0;
      acc_reg   <= '0;
      fault_reg <= 1'b0;
      rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      store_reg <= store_next;
      size_reg  <= size_next;
      uns_reg   <= uns_next;
      acc_reg   <= acc_next;
      fault_reg <= fault_next;
      rdata_reg <= rdata_next;
    end
  end

  // Memory-side outputs are pure decodes of state so an async reset kills a write at once.
  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    store_next = store_reg;
    size_next  = size_reg;
    uns_next   = uns_reg;
    acc_next   = acc_reg;
    fault_next = fault_reg;
    rdata_next = rdata_reg;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    mem_addr   = '0;
    mem_data   = '0;
    mem_wren   = 1'b0;
    mem_mask   = '0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_next  = req_addr;
          wdata_next = req_wdata;
          store_next = req_store;
          size_next  = req_size;
          uns_next   = req_unsigned;
          acc_next   = '0;
          fault_next = 1'b0;
          rdata_next = '0;
          state_next = (req_store && req_split && PROBE_SPLIT_STORES) ? PROBE : LO;
        end
      end
      PROBE: begin
        mem_addr = hi_addr;
        if (mem_exc) begin
          fault_next = 1'b1;
          state_next = RESP;
        end else begin
          state_next = LO;
        end
      end
      LO: begin
        mem_addr = base_addr;
        mem_wren = beat_write;
        if (beat_write) begin
          mem_mask = m16[7:0];
          mem_data = lo_wdata;
        end
        acc_next = lo_lane;
        if (mem_exc) begin
          fault_next = 1'b1;
          state_next = RESP;
        end else if (split) begin
          state_next = HI;
        end else begin
          rdata_next = store_reg ? '0 : extend(lo_lane, size_reg, uns_reg);
          state_next = RESP;
        end
      end
      HI: begin
        mem_addr = hi_addr;
        mem_wren = beat_write;
        if (beat_write) begin
          mem_mask = m16[15:8];
          mem_data = hi_wdata;
        end
        if (mem_exc) begin
          fault_next = 1'b1;
          rdata_next = '0;
        end else begin
          rdata_next = store_reg ? '0 : extend(acc_reg | hi_lane, size_reg, uns_reg);
        end
        state_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: byte-level memory model with a
// fault window, directed scenarios with literal expectations, then random traffic.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [63:0] req_addr = '0;
  logic        req_store = 1'b0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic [63:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_data;
  logic        rsp_fault;
  logic [63:0] mem_addr;
  logic [63:0] mem_data;
  logic        mem_wren;
  logic [7:0]  mem_mask;
  logic [63:0] mem_resp = '0;
  logic        mem_exc = 1'b0;

  int checks = 0;
  int failures = 0;
  int mem_gen = 0;

  bit [7:0]    mem_b [bit [63:0]];
  bit [7:0]    ref_b [bit [63:0]];
  logic [63:0] wl_addr [$];
  logic [7:0]  wl_mask [$];
  logic [63:0] wl_data [$];
  logic [63:0] trace_q [$];

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_store(req_store), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_fault(rsp_fault),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren), .mem_mask(mem_mask),
    .mem_resp(mem_resp), .mem_exc(mem_exc)
  );

  function automatic bit beat_faults(input bit [63:0] beat);
    return (beat >= 64'h100000) && (beat < 64'h100100);
  endfunction

  function automatic logic [7:0] mem_rd(input bit [63:0] a);
    return mem_b.exists(a) ? mem_b[a] : 8'h00;
  endfunction

  function automatic logic [7:0] ref_rd(input bit [63:0] a);
    return ref_b.exists(a) ? ref_b[a] : 8'h00;
  endfunction

  function automatic logic [63:0] beat_rd(input bit [63:0] a);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = mem_rd(a + 64'(i));
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%h required=0x%h", name, act, exp);
    end
  endtask

  // Combinational memory: read data and fault follow mem_addr and every write.
  always @(mem_addr or mem_gen) begin
    mem_resp = beat_rd(mem_addr);
    mem_exc  = beat_faults({mem_addr[63:3], 3'b000});
  end

  always @(posedge clk) begin
    if (mem_wren) begin
      for (int i = 0; i < 8; i++)
        if (mem_mask[i]) mem_b[mem_addr + 64'(i)] = mem_data[8*i +: 8];
      wl_addr.push_back(mem_addr);
      wl_mask.push_back(mem_mask);
      wl_data.push_back(mem_data);
      mem_gen++;
    end
  end

  // Per-cycle interface invariants.
  always @(negedge clk) begin
    if (rst_n) begin
      if (!mem_wren) chk("mask_without_wren", mem_mask, 0);
      if (mem_exc) chk("wren_during_exc", mem_wren, 0);
      chk("beat_alignment", mem_addr[2:0], 0);
      chk("ready_valid_overlap", req_ready & rsp_valid, 0);
    end
  end

  task automatic do_req(input logic [63:0] a, input logic st, input logic [1:0] sz,
                        input logic un, input logic [63:0] wd, input int bp,
                        output logic [63:0] got_data, output logic got_fault,
                        output int got_lat);
    int          n_bytes, off, lat_exp, n;
    bit          split, lo_f, hi_f, flt;
    logic [63:0] exp_data;
    n_bytes = 1 << sz;
    off     = int'(a[2:0]);
    split   = (off + n_bytes) > 8;
    lo_f    = beat_faults(a & ~64'h7);
    hi_f    = split && beat_faults((a & ~64'h7) + 64'd8);
    flt     = lo_f || hi_f;
    if (!split)   lat_exp = 2;
    else if (!st) lat_exp = lo_f ? 2 : 3;
    else          lat_exp = hi_f ? 2 : (lo_f ? 3 : 4);
    exp_data = '0;
    if (!st && !flt) begin
      for (int i = 0; i < n_bytes; i++) exp_data[8*i +: 8] = ref_rd(a + 64'(i));
      if (!un && n_bytes < 8 && exp_data[8*n_bytes-1]) exp_data |= ~64'h0 << (8*n_bytes);
    end
    if (st && !flt)
      for (int i = 0; i < n_bytes; i++) ref_b[a + 64'(i)] = wd[8*i +: 8];

    @(posedge clk); #1;
    req_addr = a; req_store = st; req_size = sz; req_unsigned = un; req_wdata = wd;
    req_valid = 1'b1;
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    trace_q.delete();
    n = 0;
    while (1) begin
      @(negedge clk);
      if (rsp_valid) break;
      trace_q.push_back(mem_addr);
      n++;
      if (n > 10) begin
        failures++;
        $display("FAIL rsp_timeout actual=no_rsp_valid required=rsp_valid addr=0x%h", a);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
      @(posedge clk);
    end
    got_lat   = n + 1;
    got_data  = rsp_data;
    got_fault = rsp_fault;
    chk("latency", 64'(got_lat), 64'(lat_exp));
    chk("rsp_data", rsp_data, exp_data);
    chk("rsp_fault", rsp_fault, flt);

    for (int k = 0; k < bp; k++) begin
      @(posedge clk); #1;
      req_valid = 1'b1; req_store = 1'b1; req_size = 2'd3;
      req_addr = 64'h40; req_wdata = {$urandom, $urandom};
      @(negedge clk);
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_data", rsp_data, exp_data);
      chk("bp_rsp_fault", rsp_fault, flt);
      chk("bp_req_ready", req_ready, 0);
    end
    @(posedge clk); #1;
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("idle_after_rsp", req_ready, 1);
    chk("no_stale_rsp", rsp_valid, 0);
    for (int i = -1; i <= n_bytes; i++)
      chk("mem_byte", mem_rd(a + 64'(i)), ref_rd(a + 64'(i)));
  endtask

  initial begin
    logic [63:0] d;
    logic        f;
    int          lat, wl0;
    logic [7:0]  b;

    for (int i = 0; i < 'h200; i++) begin
      b = 8'($urandom);
      mem_b[64'(i)] = b; ref_b[64'(i)] = b;
    end
    for (int i = 'hFFF00; i < 'h100000; i++) begin
      b = 8'($urandom);
      mem_b[64'(i)] = b; ref_b[64'(i)] = b;
    end
    for (int i = 0; i < 4; i++) begin
      mem_b[64'h0FFFFC + 64'(i)] = 8'hA1 + 8'(i);
      ref_b[64'h0FFFFC + 64'(i)] = 8'hA1 + 8'(i);
    end

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_mem_wren", mem_wren, 0);
    chk("rst_mem_mask", mem_mask, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_fault", rsp_fault, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Aligned doubleword store, then sub-word loads out of it
    wl0 = wl_addr.size();
    do_req(64'h100, 1'b1, 2'd3, 1'b0, 64'h1122334455667788, 0, d, f, lat);
    chk("st_d_lat", 64'(lat), 2);
    chk("st_d_beats", 64'(wl_addr.size() - wl0), 1);
    if (wl_addr.size() > wl0) begin
      chk("st_d_addr", wl_addr[wl0], 64'h100);
      chk("st_d_mask", wl_mask[wl0], 8'hFF);
    end
    do_req(64'h104, 1'b0, 2'd2, 1'b0, 64'h0, 0, d, f, lat);
    chk("ld_w_104", d, 64'h11223344);
    do_req(64'h107, 1'b0, 2'd0, 1'b0, 64'h0, 0, d, f, lat);
    chk("ld_b_107", d, 64'h11);

    // Split halfword store across 0x100 with probe
    wl0 = wl_addr.size();
    do_req(64'hFF, 1'b1, 2'd1, 1'b0, 64'hBEEF, 0, d, f, lat);
    chk("split_st_lat", 64'(lat), 4);
    chk("split_st_trace_len", 64'(trace_q.size()), 3);
    if (trace_q.size() == 3) begin
      chk("split_st_probe", trace_q[0], 64'h100);
      chk("split_st_lo", trace_q[1], 64'hF8);
      chk("split_st_hi", trace_q[2], 64'h100);
    end
    chk("split_st_beats", 64'(wl_addr.size() - wl0), 2);
    if (wl_addr.size() == wl0 + 2) begin
      chk("split_lo_addr", wl_addr[wl0], 64'hF8);
      chk("split_lo_mask", wl_mask[wl0], 8'h80);
      chk("split_lo_data", wl_data[wl0][63:56], 8'hEF);
      chk("split_hi_addr", wl_addr[wl0+1], 64'h100);
      chk("split_hi_mask", wl_mask[wl0+1], 8'h01);
      chk("split_hi_data", wl_data[wl0+1][7:0], 8'hBE);
    end
    do_req(64'hFF, 1'b0, 2'd1, 1'b0, 64'h0, 0, d, f, lat);
    chk("split_ld_signed", d, 64'hFFFFFFFFFFFFBEEF);
    chk("split_ld_lat", 64'(lat), 3);
    do_req(64'hFF, 1'b0, 2'd1, 1'b1, 64'h0, 0, d, f, lat);
    chk("split_ld_unsigned", d, 64'hBEEF);

    // Faults
    do_req(64'h100000, 1'b0, 2'd2, 1'b0, 64'h0, 0, d, f, lat);
    chk("ld_fault_flag", f, 1);
    chk("ld_fault_data", d, 0);
    wl0 = wl_addr.size();
    do_req(64'hFFFFC, 1'b1, 2'd3, 1'b0, 64'hDEADBEEFCAFEF00D, 0, d, f, lat);
    chk("probe_fault_flag", f, 1);
    chk("probe_fault_writes", 64'(wl_addr.size() - wl0), 0);
    for (int i = 0; i < 4; i++)
      chk("probe_fault_bytes", mem_rd(64'hFFFFC + 64'(i)), 8'hA1 + 8'(i));

    // Backpressure on a loaded doubleword
    do_req(64'h100, 1'b0, 2'd3, 1'b0, 64'h0, 5, d, f, lat);
    chk("bp_ld_d", d, 64'h11223344556677BE);

    // Random traffic against the model
    for (int t = 0; t < 300; t++) begin
      logic [63:0] a;
      case ($urandom_range(0, 3))
        0, 1:    a = 64'($urandom_range(0, 'h1F8));
        2:       a = 64'h100000 - 64'($urandom_range(1, 16));
        default: a = 64'h100000 + 64'($urandom_range(0, 8));
      endcase
      do_req(a, 1'($urandom), 2'($urandom), 1'($urandom), {$urandom, $urandom},
             $urandom_range(0, 3), d, f, lat);
    end

    // Reset while the high beat of a split store is being written
    for (int i = 0; i < 2; i++) ref_b[64'hFF + 64'(i)] = mem_rd(64'hFF + 64'(i));
    @(posedge clk); #1;
    req_addr = 64'hFF; req_store = 1'b1; req_size = 2'd1; req_unsigned = 1'b0;
    req_wdata = 64'h1234; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("hi_beat_wren", mem_wren, 1);
    chk("hi_beat_addr", mem_addr, 64'h100);
    rst_n = 1'b0;
    #1;
    chk("async_rst_wren", mem_wren, 0);
    chk("async_rst_mask", mem_mask, 0);
    repeat (2) @(negedge clk);
    chk("mid_rst_ready", req_ready, 1);
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_addr", mem_addr, 0);
    chk("rst_lo_written", mem_rd(64'hFF), 8'h34);
    chk("rst_hi_untouched", mem_rd(64'h100), ref_rd(64'h100));
    ref_b[64'hFF] = 8'h34;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_ready", req_ready, 1);
      chk("post_rst_no_rsp", rsp_valid, 0);
    end
    do_req(64'hFF, 1'b0, 2'd1, 1'b1, 64'h0, 0, d, f, lat);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
